matrix_mult_seq: RTL and testbench

//  Control-path sequencer for the ROWxCOL weight-stationary systolic array. Latches a data_config_struct on

---
 rtl/matrix_mult_pkg.sv | 39 +++
 rtl/matrix_mult_addr_gen.sv | 26 ++
 rtl/matrix_mult_seq.sv | 169 ++++++++++++++++
 tb/tb_matrix_mult_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
// Config bundle, state encoding and tile-count helper.
package matrix_mult_pkg;

  localparam int ROW_DEF      = 4;
  localparam int COL_DEF      = 4;
  localparam int PIPE_LAT_DEF = ROW_DEF + COL_DEF;
  localparam int OFF_W        = 16;
  localparam int CNT_W        = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    IN,
    IN_OUT,
    OUT,
    DONE
  } state_struct;

  typedef struct packed {
    logic [OFF_W-1:0] w_offset;
    logic [OFF_W-1:0] i_offset;
    logic [OFF_W-1:0] psum_offset;
    logic [OFF_W-1:0] o_offset_w;
    logic [CNT_W-1:0] i_rows;
    logic [CNT_W-1:0] w_cols;
    logic             accum_en;
  } data_config_struct;

  function automatic logic [CNT_W-1:0] n_tiles(
    input logic [CNT_W-1:0] w_cols,
    input int               col
  );
    int t;
    t = (int'(w_cols) + col - 1) / col;
    return CNT_W'(t);
  endfunction

endpackage

// File: rtl/matrix_mult_addr_gen.sv
// Address generator: base + tile*stride + index,
// truncated to the memory port width (wraps silently).
module matrix_mult_addr_gen
  import matrix_mult_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic [OFF_W-1:0] base,
  input  logic [CNT_W-1:0] tile,
  input  logic [CNT_W-1:0] stride,
  input  logic [CNT_W-1:0] idx,
  output logic [AW-1:0]    addr
);

  localparam int SW = (OFF_W > 2*CNT_W) ? OFF_W + 1 : 2*CNT_W + 1;

  logic [SW-1:0] sum;
  logic          unused_hi;

  assign sum = SW'(base)
             + SW'(tile) * SW'(stride)
             + SW'(idx);
  assign addr = sum[AW-1:0];
  assign unused_hi = ^sum[SW-1:AW];

endmodule

// File: rtl/matrix_mult_seq.sv
// Control sequencer for the weight-stationary systolic array:
// walks tiles through LOAD/IN/IN_OUT/OUT and drives memory ports.
module matrix_mult_seq
  import matrix_mult_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ROW      = ROW_DEF,
  parameter int COL      = COL_DEF,
  parameter int W_SIZE   = 512,
  parameter int I_SIZE   = 512,
  parameter int O_SIZE   = 512,
  parameter int PIPE_LAT = ROW + COL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  data_config_struct         cfg,
  output logic                      w_ren,
  output logic [$clog2(W_SIZE)-1:0] w_addr,
  output logic                      i_ren,
  output logic [$clog2(I_SIZE)-1:0] i_addr,
  output logic                      psum_ren,
  output logic [$clog2(O_SIZE)-1:0] psum_addr,
  output logic                      o_wen,
  output logic [$clog2(O_SIZE)-1:0] o_addr,
  output logic                      arr_load,
  output logic                      arr_valid,
  output state_struct               state,
  output logic                      busy,
  output logic                      done
);

  localparam int KW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unused_width = WIDTH;

  state_struct       state_q, state_d;
  data_config_struct cfg_q;
  logic [CNT_W-1:0]  ntiles_q;
  logic [CNT_W-1:0]  t_q, n_q, m_q, p_q;
  logic [KW-1:0]     k_q;
  logic [PIPE_LAT-1:0] pipe_q;
  logic              arr_load_q;
  logic              last_k, last_in, last_out, last_p;
  logic              more_tiles;
  logic [CNT_W-1:0]  rows_m1;

  assign rows_m1    = cfg_q.i_rows - CNT_W'(1);
  assign w_ren      = (state_q == LOAD);
  assign i_ren      = (state_q == IN) || (state_q == IN_OUT);
  assign o_wen      = pipe_q[PIPE_LAT-1];
  assign psum_ren   = cfg_q.accum_en & pipe_q[PIPE_LAT-2];
  assign arr_load   = arr_load_q;
  assign arr_valid  = pipe_q[0];
  assign state      = state_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign last_k     = (k_q == KW'(ROW - 1));
  assign last_in    = i_ren && (n_q == rows_m1);
  assign last_out   = o_wen && (m_q == rows_m1);
  assign last_p     = (p_q == rows_m1);
  assign more_tiles = ({1'b0, t_q} + (CNT_W+1)'(1)) < {1'b0, ntiles_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; abort overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg.i_rows == '0 || cfg.w_cols == '0)
            state_d = DONE;
          else
            state_d = LOAD;
        end
      end
      LOAD:   if (last_k) state_d = IN;
      IN: begin
        if (last_in)                     state_d = OUT;
        else if (pipe_q[PIPE_LAT-2])     state_d = IN_OUT;
      end
      IN_OUT: if (last_in) state_d = OUT;
      OUT: begin
        if (last_out) state_d = more_tiles ? LOAD : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Config latch, index counters and in-flight tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      ntiles_q   <= '0;
      t_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      m_q        <= '0;
      p_q        <= '0;
      pipe_q     <= '0;
      arr_load_q <= 1'b0;
    end else if (abort) begin
      t_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      m_q        <= '0;
      p_q        <= '0;
      pipe_q     <= '0;
      arr_load_q <= 1'b0;
    end else begin
      pipe_q     <= {pipe_q[PIPE_LAT-2:0], i_ren};
      arr_load_q <= w_ren;
      if (state_q == IDLE && start) begin
        cfg_q    <= cfg;
        ntiles_q <= n_tiles(cfg.w_cols, COL);
        t_q      <= '0;
        k_q      <= '0;
        n_q      <= '0;
        m_q      <= '0;
        p_q      <= '0;
      end
      if (w_ren)    k_q <= last_k ? '0 : k_q + KW'(1);
      if (i_ren)    n_q <= last_in ? '0 : n_q + CNT_W'(1);
      if (o_wen)    m_q <= last_out ? '0 : m_q + CNT_W'(1);
      if (psum_ren) p_q <= last_p ? '0 : p_q + CNT_W'(1);
      if (last_out && more_tiles) t_q <= t_q + CNT_W'(1);
    end
  end

  matrix_mult_addr_gen #(.AW($clog2(W_SIZE))) u_w_gen (
    .base   (cfg_q.w_offset),
    .tile   (t_q),
    .stride (CNT_W'(ROW)),
    .idx    (CNT_W'(k_q)),
    .addr   (w_addr)
  );

  matrix_mult_addr_gen #(.AW($clog2(I_SIZE))) u_i_gen (
    .base   (cfg_q.i_offset),
    .tile   ('0),
    .stride ('0),
    .idx    (n_q),
    .addr   (i_addr)
  );

  matrix_mult_addr_gen #(.AW($clog2(O_SIZE))) u_p_gen (
    .base   (cfg_q.psum_offset),
    .tile   (t_q),
    .stride (cfg_q.i_rows),
    .idx    (p_q),
    .addr   (psum_addr)
  );

  matrix_mult_addr_gen #(.AW($clog2(O_SIZE))) u_o_gen (
    .base   (cfg_q.o_offset_w),
    .tile   (t_q),
    .stride (cfg_q.i_rows),
    .idx    (m_q),
    .addr   (o_addr)
  );

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq: cycle timeline
// model built from tile/row arithmetic, compared per stream.
module tb_matrix_mult_seq;
  import matrix_mult_pkg::*;

  localparam int ROW  = 4;
  localparam int COL  = 4;
  localparam int L    = 8;
  localparam int DEP  = 512;
  localparam int MAXC = 256;
  localparam int NS   = 8;

  logic clk, rst_n, start, abort;
  data_config_struct cfg_in;
  logic w_ren, i_ren, psum_ren, o_wen;
  logic [8:0] w_addr, i_addr, psum_addr, o_addr;
  logic arr_load, arr_valid, busy, done;
  state_struct state;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_s [NS][MAXC];
  int act_s [NS][MAXC];
  int exp_d;
  bit exp_inout, act_inout;

  matrix_mult_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg(cfg_in),
    .w_ren(w_ren), .w_addr(w_addr),
    .i_ren(i_ren), .i_addr(i_addr),
    .psum_ren(psum_ren), .psum_addr(psum_addr),
    .o_wen(o_wen), .o_addr(o_addr),
    .arr_load(arr_load), .arr_valid(arr_valid),
    .state(state), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string sname(int s);
    case (s)
      0: return "w_rd";
      1: return "i_rd";
      2: return "psum_rd";
      3: return "o_wr";
      4: return "arr_load";
      5: return "arr_valid";
      6: return "busy";
      default: return "done";
    endcase
  endfunction

  function automatic data_config_struct mk(
    int wo, int io, int po, int oo, int ir, int wc, bit acc);
    data_config_struct c;
    c.w_offset    = OFF_W'(wo);
    c.i_offset    = OFF_W'(io);
    c.psum_offset = OFF_W'(po);
    c.o_offset_w  = OFF_W'(oo);
    c.i_rows      = CNT_W'(ir);
    c.w_cols      = CNT_W'(wc);
    c.accum_en    = acc;
    return c;
  endfunction

  function automatic data_config_struct rand_cfg(int max_r, int max_c);
    return mk($urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, max_r), $urandom_range(0, max_c),
              1'($urandom));
  endfunction

  function automatic void put(int s, int cy, int v);
    if (cy >= 0 && cy < MAXC) exp_s[s][cy] = v;
  endfunction

  // Timeline per tile: ROW load cycles, then i_rows inputs;
  // output n lands L cycles after input n; next tile follows.
  function automatic void fill_model(data_config_struct c);
    int b, nt, ir;
    for (int s = 0; s < NS; s++)
      for (int cy = 0; cy < MAXC; cy++) begin
        exp_s[s][cy] = -1;
        act_s[s][cy] = -1;
      end
    act_inout = 1'b0;
    ir = int'(c.i_rows);
    nt = (c.w_cols == 0 || ir == 0) ? 0 : (int'(c.w_cols) + COL - 1) / COL;
    b = 0;
    for (int t = 0; t < nt; t++) begin
      for (int k = 0; k < ROW; k++)
        put(0, b + k, (int'(c.w_offset) + t*ROW + k) % DEP);
      for (int n = 0; n < ir; n++) begin
        put(1, b + ROW + n, (int'(c.i_offset) + n) % DEP);
        put(3, b + ROW + n + L, (int'(c.o_offset_w) + t*ir + n) % DEP);
        if (c.accum_en)
          put(2, b + ROW + n + L - 1, (int'(c.psum_offset) + t*ir + n) % DEP);
      end
      b += ROW + ir + L;
    end
    exp_d = b;
    for (int cy = 0; cy <= b; cy++) put(6, cy, 1);
    put(7, b, 1);
    for (int cy = 1; cy < MAXC; cy++) begin
      if (exp_s[0][cy-1] >= 0) exp_s[4][cy] = 1;
      if (exp_s[1][cy-1] >= 0) exp_s[5][cy] = 1;
    end
    exp_inout = (nt > 0) && (ir > L);
  endfunction

  function automatic int stream_diff(int s);
    for (int cy = 0; cy < MAXC; cy++)
      if (act_s[s][cy] != exp_s[s][cy]) return cy;
    return -1;
  endfunction

  task automatic sample(int cy);
    act_s[0][cy] = w_ren     ? int'(w_addr)    : -1;
    act_s[1][cy] = i_ren     ? int'(i_addr)    : -1;
    act_s[2][cy] = psum_ren  ? int'(psum_addr) : -1;
    act_s[3][cy] = o_wen     ? int'(o_addr)    : -1;
    act_s[4][cy] = arr_load  ? 1 : -1;
    act_s[5][cy] = arr_valid ? 1 : -1;
    act_s[6][cy] = busy      ? 1 : -1;
    act_s[7][cy] = done      ? 1 : -1;
    if (state == IN_OUT) act_inout = 1'b1;
  endtask

  // Launch one operation; cfg and start are scrambled while busy
  task automatic run_op(data_config_struct c);
    fill_model(c);
    @(negedge clk);
    cfg_in = c;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cy = 0; cy < MAXC && cy <= exp_d + 2; cy++) begin
      sample(cy);
      cfg_in = rand_cfg(20, 12);
      start  = (cy <= exp_d) ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b1;
    abort  = 1'b0;
    cfg_in = rand_cfg(20, 12);
    repeat (3) @(negedge clk);
    n_checks++;
    if (state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", state, IDLE);
    end
    n_checks++;
    if ({w_ren, i_ren, psum_ren, o_wen, arr_load, arr_valid, busy, done} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {w_ren, i_ren, psum_ren, o_wen, arr_load, arr_valid, busy, done});
    end
    n_checks++;
    if ({w_addr, i_addr, psum_addr, o_addr} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected 0",
               {w_addr, i_addr, psum_addr, o_addr});
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state !== IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got state %0d busy %b expected 0/0", state, busy);
    end
  endtask

  task automatic test_directed;
    data_config_struct cl [6];
    string tag;
    cl[0] = mk(0, 0, 0, 0, 8, 4, 0);
    cl[1] = mk(0, 0, 0, 100, 6, 10, 0);
    cl[2] = mk(0, 0, 0, 0, 3, 4, 0);
    cl[3] = mk(20, 7, 50, 300, 5, 4, 1);
    cl[4] = mk(509, 510, 0, 0, 4, 4, 0);
    cl[5] = mk(0, 0, 0, 0, 12, 5, 1);
    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("directed%0d", i);
      run_op(cl[i]);
      for (int s = 0; s < NS; s++) begin
        int d;
        n_checks++;
        d = stream_diff(s);
        if (d >= 0) begin
          n_fail++;
          $display("FAIL %s %s cycle %0d: got %0d expected %0d",
                   tag, sname(s), d, act_s[s][d], exp_s[s][d]);
        end
      end
      n_checks++;
      if (act_inout !== exp_inout) begin
        n_fail++;
        $display("FAIL %s in_out_visit: got %b expected %b", tag, act_inout, exp_inout);
      end
    end
  endtask

  task automatic test_empty;
    data_config_struct cl [2];
    cl[0] = mk(0, 0, 0, 0, 0, 4, 1);
    cl[1] = mk(0, 0, 0, 0, 7, 0, 0);
    for (int i = 0; i < 2; i++) begin
      run_op(cl[i]);
      for (int s = 0; s < NS; s++) begin
        int d;
        n_checks++;
        d = stream_diff(s);
        if (d >= 0) begin
          n_fail++;
          $display("FAIL empty%0d %s cycle %0d: got %0d expected %0d",
                   i, sname(s), d, act_s[s][d], exp_s[s][d]);
        end
      end
    end
  endtask

  task automatic test_abort;
    data_config_struct c;
    bit found;
    int cnt;
    c = mk(0, 0, 0, 0, 12, 4, 1);
    @(negedge clk);
    cfg_in = c;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (state == IN_OUT) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_reach_in_out: got timeout expected IN_OUT");
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if (state !== IDLE) begin
      n_fail++;
      $display("FAIL abort_state: got %0d expected %0d", state, IDLE);
    end
    n_checks++;
    if ({w_ren, i_ren, psum_ren, o_wen, arr_load, arr_valid, busy, done} !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_flags: got %b expected 00000000",
               {w_ren, i_ren, psum_ren, o_wen, arr_load, arr_valid, busy, done});
    end
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_wen || done || busy || psum_ren) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", cnt);
    end
    run_op(c);
    for (int s = 0; s < NS; s++) begin
      int d;
      n_checks++;
      d = stream_diff(s);
      if (d >= 0) begin
        n_fail++;
        $display("FAIL abort_restart %s cycle %0d: got %0d expected %0d",
                 sname(s), d, act_s[s][d], exp_s[s][d]);
      end
    end
  endtask

  task automatic test_random;
    data_config_struct c;
    for (int i = 0; i < 10; i++) begin
      c = rand_cfg(20, 12);
      run_op(c);
      for (int s = 0; s < NS; s++) begin
        int d;
        n_checks++;
        d = stream_diff(s);
        if (d >= 0) begin
          n_fail++;
          $display("FAIL random%0d %s cycle %0d: got %0d expected %0d",
                   i, sname(s), d, act_s[s][d], exp_s[s][d]);
        end
      end
      n_checks++;
      if (act_inout !== exp_inout) begin
        n_fail++;
        $display("FAIL random%0d in_out_visit: got %b expected %b",
                 i, act_inout, exp_inout);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_empty;
    test_abort;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
